iter_task_sched: RTL

- Top-level ap_ctrl sequencer that runs a group of NUM_TASKS child tasks (Mmap2Stream / yshift / Stream2Mmap style) for a programmable number of iterations.
- Each iteration: all tasks are launched together, then the scheduler waits until every task has reported done, then advances a shared 64-bit base address by a stride.
- It sits between the host-facing ap_ctrl interface and the per-task ap_ctrl ports. It replaces the single-shot start/done controller when a kernel processes memory in tiles.

---
 rtl/iter_task_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/iter_task_sched.sv
// iter_task_sched: ap_ctrl sequencer that launches NUM_TASKS child tasks per iteration,
// waits for all of them, then advances a shared 64-bit base address. Watchdog: ITER_TASK_SCHED_WDOG_EN.
module iter_task_sched #(
    parameter int NUM_TASKS   = 6,
    parameter int ITER_W      = 32,
    parameter int WDOG_CYCLES = 1048576
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic                 ap_idle,
    input  logic [ITER_W-1:0]    iters,
    input  logic [63:0]          base,
    input  logic [63:0]          stride,
    output logic [NUM_TASKS-1:0] task_ap_start,
    input  logic [NUM_TASKS-1:0] task_ap_ready,
    input  logic [NUM_TASKS-1:0] task_ap_done,
    input  logic [NUM_TASKS-1:0] task_ap_idle,
    output logic [63:0]          task_base,
    output logic [ITER_W-1:0]    iter_idx,
    output logic                 wdog_err
);

`ifdef ITER_TASK_SCHED_WDOG_EN
    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_NEXT, ST_DONE, ST_ABORT} top_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_NEXT, ST_DONE} top_state_t;
`endif

    typedef enum logic [1:0] {
        T_IDLE  = 2'b00,
        T_START = 2'b01,
        T_FIN   = 2'b10,
        T_WAIT  = 2'b11
    } task_state_t;

    top_state_t                      state_q, state_d;
    logic [NUM_TASKS-1:0][1:0]       task_q, task_d;
    logic [ITER_W-1:0]               iters_q, iters_d;
    logic [ITER_W-1:0]               iter_idx_q, iter_idx_d;
    logic [63:0]                     stride_q, stride_d;
    logic [63:0]                     base_q, base_d;
    logic                            all_fin;
    logic                            launch;
    logic                            clear;
    logic                            unused_idle;

    // Task idle flags are observed by the host side only; they never steer the sequencer.
    assign unused_idle = ^task_ap_idle;

`ifdef ITER_TASK_SCHED_WDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
`else
    logic unused_wdog;
    assign unused_wdog = |WDOG_CYCLES;
`endif

    always_comb begin
        all_fin = 1'b1;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (task_q[i] != T_FIN) all_fin = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        iters_d    = iters_q;
        iter_idx_d = iter_idx_q;
        stride_d   = stride_q;
        base_d     = base_q;
        launch     = 1'b0;
        clear      = 1'b0;
`ifdef ITER_TASK_SCHED_WDOG_EN
        wdog_err_d = wdog_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    iters_d    = iters;
                    stride_d   = stride;
                    base_d     = base;
                    iter_idx_d = '0;
`ifdef ITER_TASK_SCHED_WDOG_EN
                    wdog_err_d = 1'b0;
`endif
                    if (iters == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        launch  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (all_fin) begin
                    state_d = ST_NEXT;
`ifdef ITER_TASK_SCHED_WDOG_EN
                end else if (wdog_cnt_q == WDOG_LAST) begin
                    state_d    = ST_ABORT;
                    clear      = 1'b1;
                    wdog_err_d = 1'b1;
`endif
                end
            end
            ST_NEXT: begin
                if (iter_idx_q == iters_q - ITER_W'(1)) begin
                    state_d = ST_DONE;
                    clear   = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    iter_idx_d = iter_idx_q + ITER_W'(1);
                    base_d     = base_q + stride_q;
                    launch     = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef ITER_TASK_SCHED_WDOG_EN
            ST_ABORT: state_d = ST_DONE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshakes only move a task while the group is running; T_IDLE and T_FIN ignore them.
    always_comb begin
        task_d = task_q;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (launch) begin
                task_d[i] = T_START;
            end else if (clear) begin
                task_d[i] = T_IDLE;
            end else if (state_q == ST_RUN) begin
                case (task_q[i])
                    T_START: begin
                        if (task_ap_ready[i] && task_ap_done[i]) task_d[i] = T_FIN;
                        else if (task_ap_ready[i])               task_d[i] = T_WAIT;
                    end
                    T_WAIT: begin
                        if (task_ap_done[i]) task_d[i] = T_FIN;
                    end
                    default: task_d[i] = task_q[i];
                endcase
            end
        end
    end

`ifdef ITER_TASK_SCHED_WDOG_EN
    // The budget restarts on every entry into RUN, so it bounds each iteration separately.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_q != ST_RUN) wdog_cnt_d = '0;
        else                   wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            task_q     <= '0;
            iters_q    <= '0;
            iter_idx_q <= '0;
            stride_q   <= '0;
            base_q     <= '0;
`ifdef ITER_TASK_SCHED_WDOG_EN
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            task_q     <= task_d;
            iters_q    <= iters_d;
            iter_idx_q <= iter_idx_d;
            stride_q   <= stride_d;
            base_q     <= base_d;
`ifdef ITER_TASK_SCHED_WDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            task_ap_start[i] = (task_q[i] == T_START);
        end
    end

    assign ap_done   = (state_q == ST_DONE);
    assign ap_ready  = ap_done;
    assign ap_idle   = (state_q == ST_IDLE);
    assign task_base = base_q;
    assign iter_idx  = iter_idx_q;

`ifdef ITER_TASK_SCHED_WDOG_EN
    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

endmodule
